serial_addsub32: RTL and testbench
==================================

# serial_addsub32

Bit-serial 32-bit add/subtract unit built around the existing single-bit `full_adder` cell and one carry flip-flop. It processes one bit per clock, LSB first, trading latency for area. It serves the MIPS-32 datapath's low-area arithmetic path. Operands enter through a valid/ready request port and results leave through a valid/ready response port, so the block can sit behind an issue stage and in front of writeback.

## Interface
- `WIDTH`, 32: operand/result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  request: operands and `sub` valid.
- `start_ready`  out  1  block can accept a request; equals state==IDLE.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `sub`  in  1  0 = A+B, 1 = A−B.
- `res_valid`  out  1  result fields valid; equals state==DONE.
- `res_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  sum/difference, registered.
- `cout`  out  1  carry out of MSB; for subtract, 1 = no borrow.
- `overflow`  out  1  signed overflow.
- `zero`  out  1  result == 0.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On `start_valid && start_ready`, latch `a` into shift register SA.
  - Latch `sub ? ~b : b` into SB.
  - Load carry FF with `sub`, clear bit counter, then go to RUN.
- RUN, once per cycle:
  - Feed SA[0], SB[0] and the carry FF into `full_adder`.
  - Shift its Sum into the MSB of the result shift register and shift SA/SB right.
  - Write Cout to the carry FF and increment the counter.
  - On the bit at index WIDTH−1, capture the carry-in into the MSB as `c_msb`.
  - After the WIDTH-th bit, go to DONE.
- DONE:
  - `result` = result shift register, `cout` = carry FF.
  - `overflow` = `c_msb ^ cout`, `zero` = (result == 0).
  - All outputs are held stable until `res_valid && res_ready`, then go to IDLE.
- IDLE keeps the last result fields visible but not valid.
- `start_valid` is ignored outside IDLE and while `rst` is high.
- Arithmetic is modulo 2^WIDTH. The counter is ceil(log2(WIDTH+1)) bits and never wraps inside one operation.

## Timing
- Reset (asynchronous, immediate): state=IDLE, counter=0, carry=0, result=0, cout=0, overflow=0.
- After reset, `zero` reads 1 because it is derived from result, `start_ready`=1 and `res_valid`=0.
- Accepting edge E0 moves the FSM to RUN. Bits are processed on edges E1..E_WIDTH, and E_WIDTH moves it to DONE.
- `res_valid` is first high in the cycle after E_WIDTH. Latency from acceptance is WIDTH cycles: 32 by default.
- The response handshake edge returns the FSM to IDLE. A new request can be accepted one edge later.
- Minimum issue interval is WIDTH+2 cycles. There is no overlap of consecutive operations.
- Backpressure: `res_valid` stays high and all result outputs stay constant for as long as `res_ready` is low.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No partial result is ever flagged valid.
- `res_ready` high while not in DONE has no effect.

## Structure
- Shared package `alu_pkg` holds:
  - the FSM state enum (IDLE/RUN/DONE, 2-bit encoding);
  - a width constant `DATA_W` = 32, used as the default for `WIDTH`.
- The sole sub-module is the existing `full_adder` (port order Cout, Sum, A, B, Cin), instantiated once. Everything else is one module.

## Test plan
- Add 0x00000005 + 0x00000003 → `result`=0x00000008, `cout`=0, `overflow`=0, `zero`=0. `res_valid` must rise exactly 32 cycles after acceptance.
- Add 0x7FFFFFFF + 0x00000001 → 0x80000000, `overflow`=1, `cout`=0.
- Add 0xFFFFFFFF + 0x00000001 → 0x00000000, `cout`=1, `overflow`=0, `zero`=1.
- Sub 0x00000005 − 0x00000005 → 0x00000000, `zero`=1, `cout`=1. Sub 0x00000003 − 0x00000005 → 0xFFFFFFFE, `cout`=0, `overflow`=0.
- Hold `res_ready` low 10 cycles in DONE with `start_valid` high and new operands → outputs unchanged, `start_ready`=0, nothing accepted. Raise `res_ready` → IDLE next edge, then the new request is accepted.
- Assert `rst` at the 16th RUN cycle → `res_valid`=0, `start_ready`=1, result=0 immediately. A following 1 + 1 yields 0x00000002.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the low-area arithmetic path:
//   state_t : FSM state encoding for the serial add/subtract unit
//   DATA_W  : default datapath width
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_W = 32;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell.
// Ports:
//   cout : carry out
//   sum  : sum bit
//   a, b : operand bits
//   cin  : carry in
// -----------------------------------------------------------------------------
module full_adder (
  output logic cout,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_addsub32.sv
// -----------------------------------------------------------------------------
// serial_addsub32
// Bit-serial add/subtract unit: one bit per clock, LSB first, using a single
// full_adder cell and one carry flip-flop.
// Ports:
//   clk, rst           : rising-edge clock, async active-high reset
//   start_valid/ready  : request handshake (a, b, sub sampled on acceptance)
//   a, b               : operands
//   sub                : 0 = a+b, 1 = a-b
//   res_valid/ready    : response handshake
//   result             : registered sum/difference
//   cout               : carry out of MSB (subtract: 1 = no borrow)
//   overflow           : signed overflow
//   zero               : result == 0
// -----------------------------------------------------------------------------
module serial_addsub32
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  // Counter is wide enough to hold WIDTH, so it never wraps within an operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  // Only WIDTH-1 partial bits are kept; the final bit is merged straight into
  // the result register on the last RUN edge.
  logic [WIDTH-2:0] sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] final_sum;

  full_adder u_fa (
    .cout (fa_cout),
    .sum  (fa_sum),
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry)
  );

  assign last_bit  = (cnt == LAST_BIT);
  assign final_sum = {fa_sum, sr};

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_valid) begin
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (last_bit) begin
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (res_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Serial datapath and registered result fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            sa    <= a;
            // Subtraction as a + ~b + 1: the +1 comes in through the carry.
            sb    <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          sr    <= final_sum[WIDTH-1:1];
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            result   <= final_sum;
            cout     <= fa_cout;
            // carry currently holds the carry into the MSB.
            overflow <= carry ^ fa_cout;
            zero     <= (final_sum == '0);
          end
        end
        DONE: begin
          // Result fields held; transition handled by the FSM.
        end
        default: begin
        end
      endcase
    end
  end

endmodule : serial_addsub32

// File: tb/tb_serial_addsub32.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub32
// Directed self-checking bench for serial_addsub32 with hand-computed results.
// -----------------------------------------------------------------------------
module tb_serial_addsub32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  int checks   = 0;
  int failures = 0;

  serial_addsub32 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Present a request, wait for acceptance, then count cycles until res_valid.
  task automatic issue(input logic [31:0] op_a, input logic [31:0] op_b,
                       input logic op_sub, output int lat);
    @(negedge clk);
    a = op_a; b = op_b; sub = op_sub; start_valid = 1'b1;
    check("ready_before_issue", {31'd0, start_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Check result fields, then complete the response handshake.
  task automatic expect_result(input string tag, input logic [31:0] exp_r,
                               input logic exp_c, input logic exp_o, input logic exp_z);
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_o});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_idle_ready"}, {31'd0, start_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_idle_hold"}, result, exp_r);
  endtask

  int lat;

  initial begin
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = 32'd0; b = 32'd0; sub = 1'b0;
    #12;
    check("rst_result", result, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_start_ready", {31'd0, start_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(32'h0000_0005, 32'h0000_0003, 1'b0, lat);
    check("add5_3_latency", lat, 32'd32);
    expect_result("add5_3", 32'h0000_0008, 1'b0, 1'b0, 1'b0);

    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("addovf_latency", lat, 32'd32);
    expect_result("addovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("addwrap_latency", lat, 32'd32);
    expect_result("addwrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    issue(32'h0000_0005, 32'h0000_0005, 1'b1, lat);
    check("sub5_5_latency", lat, 32'd32);
    expect_result("sub5_5", 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    issue(32'h0000_0003, 32'h0000_0005, 1'b1, lat);
    check("sub3_5_latency", lat, 32'd32);
    expect_result("sub3_5", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    issue(32'h8000_0000, 32'h0000_0001, 1'b1, lat);
    check("subovf_latency", lat, 32'd32);
    expect_result("subovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Backpressure: hold res_ready low with a pending new request.
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    check("bp_latency", lat, 32'd32);
    a = 32'd10; b = 32'd20; sub = 1'b0; start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, res_valid}, 32'd1);
      check("bp_start_ready", {31'd0, start_ready}, 32'd0);
      check("bp_result", result, 32'h2345_6789);
      check("bp_flags", {29'd0, cout, overflow, zero}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_to_idle", {31'd0, start_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    check("bp_accepted", {31'd0, start_ready}, 32'd0);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_new_latency", lat, 32'd32);
    expect_result("bp_new", 32'd30, 1'b0, 1'b0, 1'b0);

    // Reset during the 16th RUN cycle aborts the operation.
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0000_1111; sub = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_valid", {31'd0, res_valid}, 32'd0);
    check("abort_ready", {31'd0, start_ready}, 32'd1);
    check("abort_result", result, 32'd0);
    check("abort_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_stays_idle", {30'd0, res_valid, start_ready}, 32'd1);

    issue(32'h0000_0001, 32'h0000_0001, 1'b0, lat);
    check("post_rst_latency", lat, 32'd32);
    expect_result("post_rst", 32'h0000_0002, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_addsub32
